// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage.
//   Holds the fetch PC and issues in-order requests to instruction memory,
//   tolerating variable grant and response latency. Returned words are kept
//   in a small FIFO and presented to decode with op/funct3/funct7 pre-split.
//   A redirect (PCSrc/PCTarget) flushes the FIFO and drops in-flight
//   wrong-path responses.
// Ports:
//   clk, rst_n                       clock (rising edge), async active-low reset
//   imem_req/imem_addr/imem_gnt      request handshake (req && gnt)
//   imem_rvalid/imem_rdata           in-order responses
//   PCSrc/PCTarget                   redirect from execute
//   dec_valid/dec_ready              decode handshake (pop on valid && ready)
//   instr/pc/pc_plus4/op/funct3/funct7  FIFO-head instruction and fields
module fetch_unit #(
  parameter int unsigned       XLEN            = 32,
  parameter logic [XLEN-1:0]   RESET_PC        = '0,
  parameter int unsigned       FIFO_DEPTH      = 2,
  parameter int unsigned       MAX_OUTSTANDING = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [31:0]     imem_rdata,
  input  logic            PCSrc,
  input  logic [XLEN-1:0] PCTarget,
  output logic            dec_valid,
  input  logic            dec_ready,
  output logic [31:0]     instr,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus4,
  output logic [6:0]      op,
  output logic [2:0]      funct3,
  output logic            funct7
);

  localparam int unsigned CW  = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned AW  = $clog2(FIFO_DEPTH);
  localparam int unsigned NW  = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned SW  = ((CW > NW) ? CW : NW) + 1;
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_BOOT,
    S_RUN,
    S_DRAIN
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [XLEN-1:0] r_fetch_pc;
  logic [XLEN-1:0] r_resp_pc;
  logic [XLEN-1:0] w_target;
  logic [CW-1:0]   r_outstanding;
  logic [CW-1:0]   r_discard;
  logic [CW-1:0]   w_outstanding_nxt;
  logic [CW-1:0]   w_discard_nxt;
  logic [NW-1:0]   r_count;
  logic [AW-1:0]   r_rd_ptr;
  logic [AW-1:0]   r_wr_ptr;
  logic [31:0]     r_instr_q [FIFO_DEPTH];
  logic [XLEN-1:0] r_pc_q    [FIFO_DEPTH];

  logic            w_dec_valid;
  logic            w_resp;
  logic            w_pop;
  logic            w_push;
  logic            w_req;
  logic            w_grant;
  logic [SW-1:0]   w_credit;
  logic [31:0]     w_instr;
  logic [XLEN-1:0] w_pc;

  always_comb begin
    w_target    = PCTarget & ~XLEN'(3);
    w_dec_valid = (r_count != '0);
    // rvalid with nothing outstanding is a stray and is ignored
    w_resp      = imem_rvalid && (r_outstanding != '0);
    w_pop       = w_dec_valid && dec_ready && !PCSrc;
    w_push      = w_resp && (r_discard == '0) && !PCSrc;
    // Credit counts slots already promised to the FIFO. A same-cycle pop frees
    // a slot before any new response can land (earliest is next cycle), which
    // is what lets a 2-entry buffer sustain one instruction per cycle.
    w_credit    = SW'(r_outstanding) + SW'(r_count) - SW'(w_pop);
    w_req       = (r_state != S_BOOT) && !PCSrc &&
                  (r_outstanding < CW'(MAX_OUTSTANDING)) &&
                  (w_credit < SW'(FIFO_DEPTH));
    w_grant     = w_req && imem_gnt;

    w_outstanding_nxt = r_outstanding + CW'(w_grant) - CW'(w_resp);

    w_discard_nxt = r_discard;
    if (PCSrc) begin
      // everything still in flight belongs to the old path
      w_discard_nxt = r_outstanding - CW'(w_resp);
    end else if (w_resp && (r_discard != '0)) begin
      w_discard_nxt = r_discard - CW'(1);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_BOOT:  w_state_nxt = S_RUN;
      S_RUN:   if (PCSrc && (w_discard_nxt != '0)) w_state_nxt = S_DRAIN;
      S_DRAIN: if (!PCSrc && (w_discard_nxt == '0)) w_state_nxt = S_RUN;
      default: w_state_nxt = S_BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_BOOT;
      r_fetch_pc    <= RESET_PC;
      r_resp_pc     <= RESET_PC;
      r_outstanding <= '0;
      r_discard     <= '0;
      r_count       <= '0;
      r_rd_ptr      <= '0;
      r_wr_ptr      <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_outstanding <= w_outstanding_nxt;
      r_discard     <= w_discard_nxt;
      if (PCSrc) begin
        r_fetch_pc <= w_target;
        r_resp_pc  <= w_target;
        r_count    <= '0;
        r_rd_ptr   <= '0;
        r_wr_ptr   <= '0;
      end else begin
        if (w_grant) r_fetch_pc <= r_fetch_pc + XLEN'(4);
        if (w_push) begin
          r_resp_pc <= r_resp_pc + XLEN'(4);
          r_wr_ptr  <= r_wr_ptr + AW'(1);
        end
        if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
        r_count <= r_count + NW'(w_push) - NW'(w_pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_instr_q[r_wr_ptr] <= imem_rdata;
      r_pc_q[r_wr_ptr]    <= r_resp_pc;
    end
  end

  always_comb begin
    w_instr = w_dec_valid ? r_instr_q[r_rd_ptr] : NOP;
    w_pc    = w_dec_valid ? r_pc_q[r_rd_ptr]    : '0;
  end

  assign imem_req  = w_req;
  assign imem_addr = r_fetch_pc;
  assign dec_valid = w_dec_valid;
  assign instr     = w_instr;
  assign pc        = w_pc;
  assign pc_plus4  = w_pc + XLEN'(4);
  assign op        = w_instr[6:0];
  assign funct3    = w_instr[14:12];
  assign funct7    = w_instr[30];

endmodule
